// File: rtl/fs_rename_pkg.sv
// Shared rename-stage constants and the checkpoint entry layout used by the
// free-list checkpoint queue.
package fs_rename_pkg;

   localparam int NUM_CP = 8;
   localparam int CP_LOG = 3;
   localparam int FL_LOG = 7;

   localparam logic [CP_LOG:0] CP_FULL_CNT = (CP_LOG+1)'(NUM_CP);

   typedef struct packed {
      logic              valid;
      logic              resolved;
      logic [FL_LOG-1:0] head;
   } cp_entry_t;

   // Ring distance from b forward to a, mod NUM_CP.
   function automatic logic [CP_LOG-1:0] cp_dist(input logic [CP_LOG-1:0] a,
                                                 input logic [CP_LOG-1:0] b);
      return a - b;
   endfunction

endpackage

// File: rtl/cp_ring_ptr.sv
// Head/tail/occupancy bookkeeping for the checkpoint ring; all arithmetic wraps mod NUM_CP,
// and the extra count bit is what separates full from empty.
module cp_ring_ptr
   import fs_rename_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_flush,
   input  logic              i_alloc,
   input  logic              i_retire,
   input  logic              i_rollback,
   input  logic [CP_LOG-1:0] i_rollback_tag,
   output logic [CP_LOG-1:0] o_head,
   output logic [CP_LOG-1:0] o_tail,
   output logic [CP_LOG:0]   o_count
);

   logic [CP_LOG-1:0] r_head;
   logic [CP_LOG-1:0] r_tail;
   logic [CP_LOG:0]   r_count;
   logic [CP_LOG-1:0] w_head_nxt;

   // Head after this cycle's retire, which is applied before any rollback.
   always_comb begin
      w_head_nxt = r_head;
      if (i_retire) begin
         w_head_nxt = r_head + CP_LOG'(1);
      end else begin
         w_head_nxt = r_head;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (!reset || i_flush) begin
         r_head  <= {CP_LOG{1'b0}};
         r_tail  <= {CP_LOG{1'b0}};
         r_count <= {(CP_LOG+1){1'b0}};
      end else if (i_rollback) begin
         r_head  <= w_head_nxt;
         r_tail  <= i_rollback_tag;
         r_count <= {1'b0, cp_dist(i_rollback_tag, w_head_nxt)};
      end else begin
         r_head <= w_head_nxt;
         if (i_alloc) begin
            r_tail <= r_tail + CP_LOG'(1);
         end
         r_count <= r_count + {{CP_LOG{1'b0}}, i_alloc} - {{CP_LOG{1'b0}}, i_retire};
      end
   end

   assign o_head  = r_head;
   assign o_tail  = r_tail;
   assign o_count = r_count;

endmodule

// File: rtl/freelist_checkpoint_queue.sv
// Rename checkpoint queue: snapshots the free-list head per branch and restores it on mispredict.
// Optional statistics counters are enabled with the FL_CP_STATS_EN macro.
module freelist_checkpoint_queue
   import fs_rename_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_i,
   input  logic              recoverFlag_i,
   input  logic              branchValid_i,
   input  logic [FL_LOG-1:0] freeListHead_i,
   output logic [CP_LOG-1:0] allocTag_o,
   output logic              cpFull_o,
   output logic              cpEmpty_o,
   input  logic              resolveValid_i,
   input  logic [CP_LOG-1:0] resolveTag_i,
   input  logic              mispredict_i,
   output logic              ctrlVerified_o,
   output logic              flagRecoverEX_o,
`ifdef FL_CP_STATS_EN
   output logic [15:0]       mispredCnt_o,
   output logic [15:0]       fullStallCnt_o,
`endif
   output logic [FL_LOG-1:0] freeListHeadCp_o
);

   cp_entry_t         r_entry [NUM_CP];
   logic              r_ctrl_verified;
   logic              r_flag_recover;
   logic [FL_LOG-1:0] r_head_cp;

   logic [CP_LOG-1:0] w_head;
   logic [CP_LOG-1:0] w_tail;
   logic [CP_LOG:0]   w_count;
   logic [CP_LOG-1:0] w_dtag;
   logic              w_full;
   logic              w_retire;
   logic              w_hit;
   logic              w_mis_hit;
   logic              w_cor_hit;
   logic              w_alloc;

   // A tag whose entry retires this very cycle counts as already gone.
   always_comb begin
      w_full    = (w_count == CP_FULL_CNT);
      w_retire  = r_entry[w_head].valid & r_entry[w_head].resolved;
      w_hit     = resolveValid_i & r_entry[resolveTag_i].valid
                  & ~(w_retire & (resolveTag_i == w_head));
      w_mis_hit = w_hit & mispredict_i;
      w_cor_hit = w_hit & ~mispredict_i;
      w_alloc   = branchValid_i & ~stall_i & ~w_full & ~w_mis_hit;
      w_dtag    = cp_dist(resolveTag_i, w_head);
   end

   cp_ring_ptr u_ptr (
      .clk            (clk),
      .reset          (reset),
      .i_flush        (recoverFlag_i),
      .i_alloc        (w_alloc),
      .i_retire       (w_retire),
      .i_rollback     (w_mis_hit),
      .i_rollback_tag (resolveTag_i),
      .o_head         (w_head),
      .o_tail         (w_tail),
      .o_count        (w_count)
   );

   // Entry array update; head payloads are deliberately left uncleared on reset.
   always_ff @(posedge clk) begin
      if (!reset || recoverFlag_i) begin
         for (int i = 0; i < NUM_CP; i++) begin
            r_entry[i].valid    <= 1'b0;
            r_entry[i].resolved <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NUM_CP; i++) begin
            if (w_mis_hit && (cp_dist(CP_LOG'(i), w_head) >= w_dtag)) begin
               r_entry[i].valid    <= 1'b0;
               r_entry[i].resolved <= 1'b0;
            end else if (w_retire && (CP_LOG'(i) == w_head)) begin
               r_entry[i].valid    <= 1'b0;
               r_entry[i].resolved <= 1'b0;
            end else if (w_cor_hit && (CP_LOG'(i) == resolveTag_i)) begin
               r_entry[i].resolved <= 1'b1;
            end else if (w_alloc && (CP_LOG'(i) == w_tail)) begin
               r_entry[i].valid    <= 1'b1;
               r_entry[i].resolved <= 1'b0;
               r_entry[i].head     <= freeListHead_i;
            end
         end
      end
   end

   // Resolution pulses towards the free list.
   always_ff @(posedge clk) begin
      if (!reset || recoverFlag_i) begin
         r_ctrl_verified <= 1'b0;
         r_flag_recover  <= 1'b0;
         r_head_cp       <= {FL_LOG{1'b0}};
      end else begin
         r_ctrl_verified <= w_hit;
         r_flag_recover  <= w_mis_hit;
         if (w_mis_hit) begin
            r_head_cp <= r_entry[resolveTag_i].head;
         end else begin
            r_head_cp <= {FL_LOG{1'b0}};
         end
      end
   end

`ifdef FL_CP_STATS_EN
   logic [15:0] r_mispred_cnt;
   logic [15:0] r_full_stall_cnt;

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (!reset || recoverFlag_i) begin
         r_mispred_cnt    <= 16'h0000;
         r_full_stall_cnt <= 16'h0000;
      end else begin
         if (w_mis_hit && (r_mispred_cnt != 16'hFFFF)) begin
            r_mispred_cnt <= r_mispred_cnt + 16'h0001;
         end
         if (branchValid_i && w_full && (r_full_stall_cnt != 16'hFFFF)) begin
            r_full_stall_cnt <= r_full_stall_cnt + 16'h0001;
         end
      end
   end

   assign mispredCnt_o   = r_mispred_cnt;
   assign fullStallCnt_o = r_full_stall_cnt;
`endif

   assign allocTag_o       = w_tail;
   assign cpFull_o         = w_full;
   assign cpEmpty_o        = (w_count == {(CP_LOG+1){1'b0}});
   assign ctrlVerified_o   = r_ctrl_verified;
   assign flagRecoverEX_o  = r_flag_recover;
   assign freeListHeadCp_o = r_head_cp;

endmodule

// File: tb/tb_freelist_checkpoint_queue.sv
// Directed self-checking bench for freelist_checkpoint_queue.
module tb_freelist_checkpoint_queue;

   logic       clk = 1'b0;
   logic       reset;
   logic       stall_i;
   logic       recoverFlag_i;
   logic       branchValid_i;
   logic [6:0] freeListHead_i;
   logic [2:0] allocTag_o;
   logic       cpFull_o;
   logic       cpEmpty_o;
   logic       resolveValid_i;
   logic [2:0] resolveTag_i;
   logic       mispredict_i;
   logic       ctrlVerified_o;
   logic       flagRecoverEX_o;
   logic [6:0] freeListHeadCp_o;
`ifdef FL_CP_STATS_EN
   logic [15:0] mispredCnt_o;
   logic [15:0] fullStallCnt_o;
`endif

   int checks   = 0;
   int failures = 0;

   freelist_checkpoint_queue dut (
      .clk              (clk),
      .reset            (reset),
      .stall_i          (stall_i),
      .recoverFlag_i    (recoverFlag_i),
      .branchValid_i    (branchValid_i),
      .freeListHead_i   (freeListHead_i),
      .allocTag_o       (allocTag_o),
      .cpFull_o         (cpFull_o),
      .cpEmpty_o        (cpEmpty_o),
      .resolveValid_i   (resolveValid_i),
      .resolveTag_i     (resolveTag_i),
      .mispredict_i     (mispredict_i),
      .ctrlVerified_o   (ctrlVerified_o),
      .flagRecoverEX_o  (flagRecoverEX_o),
`ifdef FL_CP_STATS_EN
      .mispredCnt_o     (mispredCnt_o),
      .fullStallCnt_o   (fullStallCnt_o),
`endif
      .freeListHeadCp_o (freeListHeadCp_o)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      stall_i        = 1'b0;
      recoverFlag_i  = 1'b0;
      branchValid_i  = 1'b0;
      freeListHead_i = 7'd0;
      resolveValid_i = 1'b0;
      resolveTag_i   = 3'd0;
      mispredict_i   = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic alloc(input logic [6:0] fh);
      branchValid_i  = 1'b1;
      freeListHead_i = fh;
      tick();
      clear_inputs();
   endtask

   task automatic resolve(input logic [2:0] tag, input logic mp);
      resolveValid_i = 1'b1;
      resolveTag_i   = tag;
      mispredict_i   = mp;
      tick();
      clear_inputs();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (ctrlVerified_o !== 1'b0) begin failures++; $display("FAIL reset_ctrlv got=%0d exp=0", ctrlVerified_o); end
      checks++; if (flagRecoverEX_o !== 1'b0) begin failures++; $display("FAIL reset_flag got=%0d exp=0", flagRecoverEX_o); end
      checks++; if (freeListHeadCp_o !== 7'd0) begin failures++; $display("FAIL reset_headcp got=%0d exp=0", freeListHeadCp_o); end
      checks++; if (allocTag_o !== 3'd0) begin failures++; $display("FAIL reset_tag got=%0d exp=0", allocTag_o); end
      checks++; if (cpEmpty_o !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0d exp=1", cpEmpty_o); end
      checks++; if (cpFull_o !== 1'b0) begin failures++; $display("FAIL reset_full got=%0d exp=0", cpFull_o); end
   endtask

   task automatic test_fill();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         checks++; if (allocTag_o !== 3'(k)) begin failures++; $display("FAIL fill_tag got=%0d exp=%0d", allocTag_o, k); end
         alloc(7'(5 * (k + 1)));
      end
      checks++; if (cpFull_o !== 1'b1) begin failures++; $display("FAIL fill_full got=%0d exp=1", cpFull_o); end
      alloc(7'd99);
      checks++; if (dut.w_count !== 4'd8) begin failures++; $display("FAIL fill_drop_count got=%0d exp=8", dut.w_count); end
      checks++; if (allocTag_o !== 3'd0) begin failures++; $display("FAIL fill_drop_tag got=%0d exp=0", allocTag_o); end
      checks++; if (cpFull_o !== 1'b1) begin failures++; $display("FAIL fill_drop_full got=%0d exp=1", cpFull_o); end
   endtask

   task automatic test_resolve_correct();
      resolve(3'd0, 1'b0);
      checks++; if (ctrlVerified_o !== 1'b1) begin failures++; $display("FAIL corr_ctrlv got=%0d exp=1", ctrlVerified_o); end
      checks++; if (flagRecoverEX_o !== 1'b0) begin failures++; $display("FAIL corr_flag got=%0d exp=0", flagRecoverEX_o); end
      tick();
      checks++; if (ctrlVerified_o !== 1'b0) begin failures++; $display("FAIL corr_pulse_end got=%0d exp=0", ctrlVerified_o); end
      checks++; if (dut.w_head !== 3'd1) begin failures++; $display("FAIL corr_head got=%0d exp=1", dut.w_head); end
      checks++; if (dut.w_count !== 4'd7) begin failures++; $display("FAIL corr_count got=%0d exp=7", dut.w_count); end
   endtask

   task automatic test_mispredict();
      do_reset();
      for (int k = 0; k < 5; k++) alloc(7'(10 * (k + 1)));
      resolve(3'd2, 1'b1);
      checks++; if (ctrlVerified_o !== 1'b1) begin failures++; $display("FAIL mis_ctrlv got=%0d exp=1", ctrlVerified_o); end
      checks++; if (flagRecoverEX_o !== 1'b1) begin failures++; $display("FAIL mis_flag got=%0d exp=1", flagRecoverEX_o); end
      checks++; if (freeListHeadCp_o !== 7'd30) begin failures++; $display("FAIL mis_headcp got=%0d exp=30", freeListHeadCp_o); end
      checks++; if (allocTag_o !== 3'd2) begin failures++; $display("FAIL mis_tail got=%0d exp=2", allocTag_o); end
      checks++; if (dut.w_count !== 4'd2) begin failures++; $display("FAIL mis_count got=%0d exp=2", dut.w_count); end
      resolve(3'd3, 1'b0);
      checks++; if (ctrlVerified_o !== 1'b0) begin failures++; $display("FAIL mis_invalid_tag got=%0d exp=0", ctrlVerified_o); end
      checks++; if (flagRecoverEX_o !== 1'b0) begin failures++; $display("FAIL mis_flag_end got=%0d exp=0", flagRecoverEX_o); end
   endtask

   task automatic test_wrap();
      logic [2:0] exp_tags [4];
      exp_tags = '{3'd6, 3'd7, 3'd0, 3'd1};
      do_reset();
      for (int k = 0; k < 6; k++) alloc(7'(k + 1));
      for (int k = 0; k < 6; k++) resolve(3'(k), 1'b0);
      tick();
      checks++; if (dut.w_head !== 3'd6) begin failures++; $display("FAIL wrap_head got=%0d exp=6", dut.w_head); end
      checks++; if (cpEmpty_o !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%0d exp=1", cpEmpty_o); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (allocTag_o !== exp_tags[k]) begin failures++; $display("FAIL wrap_tag got=%0d exp=%0d", allocTag_o, exp_tags[k]); end
         alloc(7'(60 + k));
      end
      resolve(3'd7, 1'b1);
      checks++; if (freeListHeadCp_o !== 7'd61) begin failures++; $display("FAIL wrap_headcp got=%0d exp=61", freeListHeadCp_o); end
      checks++; if (allocTag_o !== 3'd7) begin failures++; $display("FAIL wrap_tail got=%0d exp=7", allocTag_o); end
      checks++; if (dut.w_count !== 4'd1) begin failures++; $display("FAIL wrap_count got=%0d exp=1", dut.w_count); end
   endtask

   task automatic test_alloc_vs_mispredict();
      for (int k = 0; k < 4; k++) alloc(7'(70 + k));
      checks++; if (dut.w_count !== 4'd5) begin failures++; $display("FAIL avm_count_pre got=%0d exp=5", dut.w_count); end
      branchValid_i  = 1'b1;
      freeListHead_i = 7'd99;
      resolve(3'd1, 1'b1);
      checks++; if (flagRecoverEX_o !== 1'b1) begin failures++; $display("FAIL avm_flag got=%0d exp=1", flagRecoverEX_o); end
      checks++; if (freeListHeadCp_o !== 7'd72) begin failures++; $display("FAIL avm_headcp got=%0d exp=72", freeListHeadCp_o); end
      checks++; if (allocTag_o !== 3'd1) begin failures++; $display("FAIL avm_tail got=%0d exp=1", allocTag_o); end
      checks++; if (dut.w_count !== 4'd3) begin failures++; $display("FAIL avm_count got=%0d exp=3", dut.w_count); end
      recoverFlag_i  = 1'b1;
      branchValid_i  = 1'b1;
      resolve(3'd0, 1'b0);
      checks++; if (cpEmpty_o !== 1'b1) begin failures++; $display("FAIL rec_empty got=%0d exp=1", cpEmpty_o); end
      checks++; if (ctrlVerified_o !== 1'b0) begin failures++; $display("FAIL rec_ctrlv got=%0d exp=0", ctrlVerified_o); end
      checks++; if (allocTag_o !== 3'd0) begin failures++; $display("FAIL rec_tail got=%0d exp=0", allocTag_o); end
      checks++; if (dut.w_head !== 3'd0) begin failures++; $display("FAIL rec_head got=%0d exp=0", dut.w_head); end
   endtask

   task automatic test_out_of_order();
      do_reset();
      for (int k = 0; k < 3; k++) alloc(7'(11 + k));
      resolve(3'd2, 1'b0);
      checks++; if (ctrlVerified_o !== 1'b1) begin failures++; $display("FAIL ooo_ctrlv2 got=%0d exp=1", ctrlVerified_o); end
      resolve(3'd1, 1'b0);
      checks++; if (dut.w_head !== 3'd0) begin failures++; $display("FAIL ooo_noretire got=%0d exp=0", dut.w_head); end
      resolve(3'd0, 1'b0);
      checks++; if (dut.w_count !== 4'd3) begin failures++; $display("FAIL ooo_count3 got=%0d exp=3", dut.w_count); end
      alloc(7'd14);
      checks++; if (dut.w_head !== 3'd1) begin failures++; $display("FAIL ooo_head1 got=%0d exp=1", dut.w_head); end
      checks++; if (dut.w_count !== 4'd3) begin failures++; $display("FAIL ooo_alloc_retire_count got=%0d exp=3", dut.w_count); end
      checks++; if (allocTag_o !== 3'd4) begin failures++; $display("FAIL ooo_tail got=%0d exp=4", allocTag_o); end
      tick();
      checks++; if (dut.w_head !== 3'd2) begin failures++; $display("FAIL ooo_head2 got=%0d exp=2", dut.w_head); end
      tick();
      checks++; if (dut.w_head !== 3'd3) begin failures++; $display("FAIL ooo_head3 got=%0d exp=3", dut.w_head); end
      tick();
      checks++; if (dut.w_count !== 4'd1) begin failures++; $display("FAIL ooo_hold_count got=%0d exp=1", dut.w_count); end
      stall_i = 1'b1;
      alloc(7'd15);
      checks++; if (allocTag_o !== 3'd4) begin failures++; $display("FAIL stall_tail got=%0d exp=4", allocTag_o); end
   endtask

   task automatic test_reset_midop();
      reset = 1'b0;
      resolve(3'd3, 1'b1);
      reset = 1'b1;
      checks++; if (ctrlVerified_o !== 1'b0) begin failures++; $display("FAIL rstmid_ctrlv got=%0d exp=0", ctrlVerified_o); end
      checks++; if (flagRecoverEX_o !== 1'b0) begin failures++; $display("FAIL rstmid_flag got=%0d exp=0", flagRecoverEX_o); end
      checks++; if (cpEmpty_o !== 1'b1) begin failures++; $display("FAIL rstmid_empty got=%0d exp=1", cpEmpty_o); end
   endtask

   initial begin
      reset = 1'b0;
      clear_inputs();
      test_reset();
      test_fill();
      test_resolve_correct();
      test_mispredict();
      test_wrap();
      test_alloc_vs_mispredict();
      test_out_of_order();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
